hc595_driver: RTL and testbench
===============================

HC595_DRIVER -- requirements
Module: hc595_driver

Interface
REQ-001 The module SHALL have parameter DIV_CNT, default 2, giving clk cycles per shift-clock half-period (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 The module SHALL have port en, input, 1 bit, which enables continuous frame refresh.
REQ-005 The module SHALL have port sel, input, 8 bits, the digit-select pattern from the hex8 scanner.
REQ-006 The module SHALL have port seg, input, 8 bits, the segment pattern from the hex8 scanner.
REQ-007 The module SHALL have port ds, output, 1 bit, the serial data to 74HC595 DS.
REQ-008 The module SHALL have port sh_cp, output, 1 bit, the shift clock to 74HC595 SH_CP.
REQ-009 The module SHALL have port st_cp, output, 1 bit, the storage/latch clock to 74HC595 ST_CP.
REQ-010 The module SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-011 The module SHALL have port done, output, 1 bit, a one-cycle pulse at the end of each frame.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and LATCH.
REQ-013 In IDLE with en=1, the FSM SHALL enter LOAD on the next cycle; with en=0 it SHALL stay in IDLE.
REQ-014 LOAD SHALL last one cycle and SHALL perform all of the following:
- capture word={seg,sel} into a 16-bit shift register;
- clear the bit counter and the divider;
- set ds=seg[7] and sh_cp=0;
- go to SHIFT.
REQ-015 In SHIFT, each bit SHALL occupy 2*DIV_CNT cycles: sh_cp low for DIV_CNT cycles, then high for DIV_CNT cycles.
REQ-016 ds SHALL be stable for the whole bit period, so the rising sh_cp edge is centred DIV_CNT cycles after the ds change.
REQ-017 At the end of each bit's high phase, the block SHALL drive sh_cp low, shift the register left by one and drive ds with the next MSB.
REQ-018 Bits SHALL be sent MSB first (seg[7] first, sel[0] last); seg therefore lands in the far cascaded 595 and sel in the near one.
REQ-019 After the 16th bit's high phase, the FSM SHALL enter LATCH with sh_cp=0.
REQ-020 In LATCH, st_cp SHALL be high for DIV_CNT cycles, then low; done SHALL pulse in the cycle st_cp falls.
REQ-021 On leaving LATCH, the FSM SHALL go to LOAD if en=1, otherwise to IDLE.
REQ-022 Frame length SHALL be 1+33*DIV_CNT cycles from the LOAD cycle to the done cycle inclusive; this is 67 cycles for DIV_CNT=2.
REQ-023 sel and seg SHALL be sampled only in LOAD; changes mid-frame SHALL NOT affect the frame in flight.
REQ-024 If en falls mid-frame, the current frame SHALL complete including LATCH, then the FSM SHALL go to IDLE.
REQ-025 sh_cp and st_cp SHALL never be high in the same cycle.
REQ-026 In IDLE, ds, sh_cp and st_cp SHALL be 0.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 Assertion of rst SHALL immediately force the following, regardless of state: state=IDLE, ds=0, sh_cp=0, st_cp=0, busy=0, done=0, shift register=0, counters=0.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no st_cp pulse; after release, the first frame SHALL start from LOAD with fresh sampling.

Configuration
REQ-030 When macro HC595_OE_EN is defined, the module SHALL add output port oe_n (1 bit, to 74HC595 OE#).
REQ-031 With HC595_OE_EN defined, oe_n SHALL be 1 at reset and SHALL go to 0 in the cycle after the first done pulse, then stay 0 until the next reset.
REQ-032 Without HC595_OE_EN, port oe_n SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-033 Single frame: DIV_CNT=2, sel=8'hFE, seg=8'hC0, en pulsed high for 1 cycle from IDLE -> bench captures ds on 16 sh_cp rising edges as 16'hC0FE; one st_cp pulse 2 cycles wide; done fires 67 cycles after LOAD; FSM returns to IDLE.
REQ-034 Continuous refresh: en held high for 3 frames, with sel changed from 8'h01 to 8'h02 during frame 1 -> frame 1 shifts 8'h01 and frame 2 shifts 8'h02; LOAD follows done with no gap.
REQ-035 Mid-frame en drop: en deasserted after 5 bits -> all 16 bits and LATCH complete, exactly one done pulse, then IDLE with ds, sh_cp and st_cp all 0.
REQ-036 Reset mid-frame: rst asserted during bit 9 -> all outputs are 0 in the same cycle with no st_cp pulse; after release with en=1, a full new frame follows.
REQ-037 Divider boundary: DIV_CNT=1, word 16'hAAAA -> sh_cp toggles every cycle, ds alternates 1,0,...; frame is 34 cycles.
REQ-038 HC595_OE_EN defined: oe_n is 1 from reset through the first frame and falls to 0 one cycle after the first done pulse; oe_n returns to 1 on rst.

Source files
------------

// File: rtl/hc595_driver.sv
// hc595_driver: serialises a 16-bit {seg,sel} word into two cascaded 74HC595
// shift registers and latches it, refreshing continuously while en is high.
//
// Frame timing (counted from the LOAD cycle):
//   LOAD   1 cycle            : {seg,sel} captured, ds = seg[7]
//   SHIFT  16 * 2*DIV_CNT     : sh_cp low DIV_CNT cycles, then high DIV_CNT
//   LATCH  DIV_CNT cycles     : st_cp high; done marks its last cycle
// This gives 1 + 33*DIV_CNT cycles, LOAD to done inclusive.
//
// Parameters:
//   DIV_CNT  clk cycles per shift-clock half-period (1..255)
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   en       enable continuous frame refresh
//   sel      digit-select pattern, shifted last (lands in the near 595)
//   seg      segment pattern, shifted first (lands in the far 595)
//   ds       serial data to 595 DS
//   sh_cp    shift clock to 595 SH_CP
//   st_cp    storage clock to 595 ST_CP
//   busy     high whenever the FSM is not IDLE
//   done     one-cycle pulse at the end of each frame
//   oe_n     output enable to 595 OE#, present only with HC595_OE_EN defined;
//            held high until the first frame has been latched
module hc595_driver #(
  parameter int DIV_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sel,
  input  logic [7:0] seg,
  output logic       ds,
  output logic       sh_cp,
  output logic       st_cp,
  output logic       busy,
  output logic       done
`ifdef HC595_OE_EN
  ,
  output logic       oe_n
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Divider terminal count, and the count one before it: done has to be
  // registered one cycle early so it lands in the last st_cp-high cycle.
  localparam logic [7:0] DIV_LAST = 8'(DIV_CNT - 1);
  localparam logic [7:0] DIV_DONE = 8'(DIV_CNT - 2);

  state_e      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        ds_q, ds_d;
  logic        sh_cp_q, sh_cp_d;
  logic        st_cp_q, st_cp_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    ds_d    = ds_q;
    sh_cp_d = sh_cp_q;
    st_cp_d = st_cp_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ds_d    = 1'b0;
        sh_cp_d = 1'b0;
        st_cp_d = 1'b0;
        if (en) state_d = LOAD;
      end

      LOAD: begin
        sr_d    = {seg, sel};
        bit_d   = 4'd0;
        div_d   = 8'd0;
        ds_d    = seg[7];
        sh_cp_d = 1'b0;
        st_cp_d = 1'b0;
        state_d = SHIFT;
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sh_cp_q) begin
            sh_cp_d = 1'b1;
          end else begin
            // End of the high phase: drop the clock and present the next bit
            // together, so ds changes a full half-period before the next rise.
            sh_cp_d = 1'b0;
            sr_d    = {sr_q[14:0], 1'b0};
            ds_d    = sr_q[14];
            if (bit_q == 4'd15) begin
              state_d = LATCH;
              st_cp_d = 1'b1;
              done_d  = (DIV_CNT == 1);
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          st_cp_d = 1'b0;
          state_d = en ? LOAD : IDLE;
        end else begin
          div_d  = div_q + 8'd1;
          done_d = (div_q == DIV_DONE);
        end
      end

      default: state_d = IDLE;
    endcase

    // busy is registered against the next state so it tracks state_q exactly.
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed in the previous cycle regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 16'd0;
      bit_q   <= 4'd0;
      div_q   <= 8'd0;
      ds_q    <= 1'b0;
      sh_cp_q <= 1'b0;
      st_cp_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ds_q    <= ds_d;
      sh_cp_q <= sh_cp_d;
      st_cp_q <= st_cp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ds    = ds_q;
  assign sh_cp = sh_cp_q;
  assign st_cp = st_cp_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef HC595_OE_EN
  // Outputs stay disabled until valid data has been latched once, so the
  // display never shows the 595s' power-up contents.
  logic oe_n_q, oe_n_d;

  always_comb begin
    oe_n_d = done_q ? 1'b0 : oe_n_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oe_n_q <= 1'b1;
    else     oe_n_q <= oe_n_d;
  end

  assign oe_n = oe_n_q;
`endif

endmodule

// File: tb/tb_hc595_driver.sv
// Testbench for hc595_driver: one instance with DIV_CNT=2 (index 0) and one
// with DIV_CNT=1 (index 1). Expected words are queued when stimulus is
// applied; a monitor reassembles ds on each sh_cp rise and compares the word
// and the frame timing when done fires.
module tb_hc595_driver;

  logic       clk;
  logic       rst;
  logic       en0, en1;
  logic [7:0] sel0, seg0, sel1, seg1;
  logic [1:0] ds_o, sh_o, st_o, busy_o, done_o;
`ifdef HC595_OE_EN
  logic [1:0] oe_o;
`endif

  hc595_driver #(.DIV_CNT(2)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .en    (en0),
    .sel   (sel0),
    .seg   (seg0),
    .ds    (ds_o[0]),
    .sh_cp (sh_o[0]),
    .st_cp (st_o[0]),
    .busy  (busy_o[0]),
    .done  (done_o[0])
`ifdef HC595_OE_EN
    ,
    .oe_n  (oe_o[0])
`endif
  );

  hc595_driver #(.DIV_CNT(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .en    (en1),
    .sel   (sel1),
    .seg   (seg1),
    .ds    (ds_o[1]),
    .sh_cp (sh_o[1]),
    .st_cp (st_o[1]),
    .busy  (busy_o[1]),
    .done  (done_o[1])
`ifdef HC595_OE_EN
    ,
    .oe_n  (oe_o[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Scoreboards, one per instance.
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  // Monitor state, indexed by instance.
  int          cyc;
  int          start_c [2];
  int          bits_c  [2];
  int          hi_c    [2];
  int          stw_c   [2];
  int          done_cnt[2];
  int          st_rise [2];
  logic [15:0] cap     [2];
  logic [1:0]  p_sh, p_st, p_busy, p_done, p_ds;
  logic        oe_at_first_done;

  initial begin
    logic [15:0] exp_w;
    cyc = 0;
    oe_at_first_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_c[i] = 0; bits_c[i] = 0; hi_c[i] = 0; stw_c[i] = 0;
      done_cnt[i] = 0; st_rise[i] = 0; cap[i] = 16'd0;
    end
    p_sh = '0; p_st = '0; p_busy = '0; p_done = '0; p_ds = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          bits_c[i] = 0; hi_c[i] = 0; stw_c[i] = 0; cap[i] = 16'd0;
        end else begin
          // A frame starts on the LOAD cycle: busy rising, or busy right after done.
          if (busy_o[i] && (!p_busy[i] || p_done[i])) begin
            start_c[i] = cyc; bits_c[i] = 0; hi_c[i] = 0; stw_c[i] = 0; cap[i] = 16'd0;
          end
          if (sh_o[i]) hi_c[i]++;
          if (sh_o[i] && !p_sh[i]) begin
            cap[i] = {cap[i][14:0], ds_o[i]};
            bits_c[i]++;
          end
          if (!sh_o[i] && p_sh[i]) check($sformatf("ds_hold%0d", i), p_ds[i], cap[i][0]);
          if (st_o[i]) begin
            stw_c[i]++;
            check($sformatf("overlap%0d", i), sh_o[i], 1'b0);
          end
          if (st_o[i] && !p_st[i]) st_rise[i]++;
          if (!st_o[i] && p_st[i]) check($sformatf("done_at_st_fall%0d", i), p_done[i], 1'b1);
          if (done_o[i]) begin
            done_cnt[i]++;
            check($sformatf("done_st_high%0d", i), st_o[i], 1'b1);
            check($sformatf("frame_len%0d", i), cyc - start_c[i] + 1, 1 + 33 * dv(i));
            check($sformatf("latch_width%0d", i), stw_c[i], dv(i));
            check($sformatf("bit_count%0d", i), bits_c[i], 16);
            check($sformatf("sh_high_cycles%0d", i), hi_c[i], 16 * dv(i));
`ifdef HC595_OE_EN
            if (i == 0 && done_cnt[0] == 1) oe_at_first_done = oe_o[0];
`endif
            if (i == 0) begin
              if (sb0.size() == 0) check("sb0_empty", 1, 0);
              else begin exp_w = sb0.pop_front(); check("word0", cap[0], exp_w); end
            end else begin
              if (sb1.size() == 0) check("sb1_empty", 1, 0);
              else begin exp_w = sb1.pop_front(); check("word1", cap[1], exp_w); end
            end
          end
        end
      end
      if (rst) begin
        p_sh = '0; p_st = '0; p_busy = '0; p_done = '0; p_ds = '0;
      end else begin
        p_sh = sh_o; p_st = st_o; p_busy = busy_o; p_done = done_o; p_ds = ds_o;
      end
    end
  end

  // Returns at the rising edge that starts the cycle after done.
  task automatic wait_done(input int i, input int budget);
    int  target;
    bit  seen;
    target = done_cnt[i] + 1;
    seen   = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk);
      if (done_cnt[i] >= target) seen = 1'b1;
    end
    if (!seen) check($sformatf("done_timeout%0d", i), 0, 1);
  endtask

  task automatic check_idle(input int i, input string tag);
    check(tag, {busy_o[i], ds_o[i], sh_o[i], st_o[i], done_o[i]}, 5'b0);
  endtask

  initial begin
    int dc;
    int sr;
    rst = 1'b1;
    en0 = 1'b0; sel0 = 8'h00; seg0 = 8'h00;
    en1 = 1'b0; sel1 = 8'h00; seg1 = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check_idle(0, "reset_out0");
    check_idle(1, "reset_out1");
`ifdef HC595_OE_EN
    check("oe_n_reset", oe_o[0], 1'b1);
`endif
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single frame, en pulsed for one cycle.
    #1 sel0 = 8'hFE; seg0 = 8'hC0; en0 = 1'b1;
    sb0.push_back(16'hC0FE);
    @(posedge clk); #1 en0 = 1'b0;
    wait_done(0, 200);
    @(negedge clk);
`ifdef HC595_OE_EN
    check("oe_n_at_first_done", oe_at_first_done, 1'b1);
    check("oe_n_after_done", oe_o[0], 1'b0);
`endif
    check_idle(0, "idle_after_single");

    // Continuous refresh, sel changed during frame 1.
    @(posedge clk); #1 sel0 = 8'h01; seg0 = 8'h3C; en0 = 1'b1;
    sb0.push_back(16'h3C01);
    repeat (20) @(posedge clk);
    #1 sel0 = 8'h02;
    sb0.push_back(16'h3C02);
    sb0.push_back(16'h3C02);
    wait_done(0, 200);
    @(negedge clk);
    check("no_gap_f2", busy_o[0], 1'b1);
    wait_done(0, 200);
    @(negedge clk);
    check("no_gap_f3", busy_o[0], 1'b1);
    repeat (10) @(posedge clk);
    #1 en0 = 1'b0;
    wait_done(0, 200);
    @(negedge clk);
    check_idle(0, "idle_after_cont");

    // en dropped after 5 bits: frame completes, exactly one done.
    @(posedge clk); #1 sel0 = 8'h81; seg0 = 8'h5A; en0 = 1'b1;
    sb0.push_back(16'h5A81);
    dc = done_cnt[0];
    repeat (21) @(posedge clk);
    #1 en0 = 1'b0;
    wait_done(0, 200);
    repeat (3) @(negedge clk);
    check_idle(0, "idle_after_drop");
    check("one_done_drop", done_cnt[0] - dc, 1);

    // Reset during bit 9: immediate clear, no st_cp, fresh frame afterwards.
    @(posedge clk); #1 sel0 = 8'h12; seg0 = 8'h34; en0 = 1'b1;
    sb0.push_back(16'h3412);
    repeat (36) @(posedge clk);
    sr = st_rise[0];
    #1 rst = 1'b1;
    void'(sb0.pop_back());
    #1 check_idle(0, "reset_mid_frame");
`ifdef HC595_OE_EN
    check("oe_n_rst", oe_o[0], 1'b1);
`endif
    sel0 = 8'h56; seg0 = 8'h78;
    sb0.push_back(16'h7856);
    repeat (2) @(posedge clk);
    check("no_st_on_abort", st_rise[0] - sr, 0);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 en0 = 1'b0;
    wait_done(0, 200);
    @(negedge clk);
    check_idle(0, "idle_after_reset_frame");

    // DIV_CNT=1 boundary, alternating word.
    @(posedge clk); #1 sel1 = 8'hAA; seg1 = 8'hAA; en1 = 1'b1;
    sb1.push_back(16'hAAAA);
    @(posedge clk); #1 en1 = 1'b0;
    wait_done(1, 100);
    @(negedge clk);
    check_idle(1, "idle_div1");

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    check("done_total0", done_cnt[0], 6);
    check("done_total1", done_cnt[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
